// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM state encodings and
// the byte-enable width used by the data port and the shared memory port.
package mem_arbiter_pkg;

    localparam int unsigned WE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_INSTR = 2'd2,
        S_DONE  = 2'd3
    } arb_state_e;

    // A transaction needs the data phase when it reads or writes any byte.
    function automatic logic is_data_access(input logic rd, input logic [WE_W-1:0] we);
        return rd || (we != '0);
    endfunction

endpackage

// File: rtl/mem_arbiter_ifetch_buf.sv
// One-entry instruction fetch buffer (address, word, valid). It is used only when
// ARB_IFETCH_BUF_EN is defined.
module ifetch_buf #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [DW-1:0] i_fill_data,
    input  logic          i_inval,
    input  logic [AW-1:0] i_inval_addr,
    input  logic [AW-1:0] i_lookup_addr,
    output logic          o_hit,
    output logic [DW-1:0] o_data
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] word_q;
    logic          inval_match;

    // Writes compare on word address; a same-cycle invalidate also masks the hit.
    assign inval_match = i_inval && valid_q && ((i_inval_addr >> 2) == (addr_q >> 2));
    assign o_hit       = valid_q && !inval_match && (i_lookup_addr == addr_q);
    assign o_data      = word_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
        end else if (i_fill) begin
            valid_q <= 1'b1;
            addr_q  <= i_fill_addr;
            word_q  <= i_fill_data;
        end else if (inval_match) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one instruction fetch and one optional data access per transaction onto a
// single shared memory port. Define ARB_IFETCH_BUF_EN to add a one-entry fetch buffer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_addr_i,
    output logic [DW-1:0]   o_data_i,
    output logic            o_valid_i,
    input  logic [AW-1:0]   i_addr_d,
    input  logic            i_rd_d,
    input  logic [WE_W-1:0] i_we_d,
    input  logic [DW-1:0]   i_data_d,
    output logic [DW-1:0]   o_data_d,
    output logic            o_valid_d,
    output logic            o_mem_req,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_rd,
    output logic [WE_W-1:0] o_mem_we,
    output logic [DW-1:0]   o_mem_data,
    input  logic            i_mem_ack,
    input  logic [DW-1:0]   i_mem_data
);

    arb_state_e      state_q, state_d;
    logic [AW-1:0]   addr_i_q;
    logic [AW-1:0]   addr_d_q;
    logic            rd_q;
    logic [WE_W-1:0] we_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   data_i_q;
    logic [DW-1:0]   data_d_q;

    logic            cap_i;
    logic            cap_d;
    logic            take_buf;
    logic            buf_hit;
    logic [DW-1:0]   buf_data;

`ifdef ARB_IFETCH_BUF_EN
    logic [AW-1:0] buf_lookup_addr;
    logic          buf_inval;

    // In S_IDLE the address is being latched this cycle, so look up the live input.
    assign buf_lookup_addr = (state_q == S_IDLE) ? i_addr_i : addr_i_q;
    assign buf_inval       = (state_q == S_DATA) && i_mem_ack && (we_q != '0);

    ifetch_buf #(
        .AW (AW),
        .DW (DW)
    ) u_ifetch_buf (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_fill        (cap_i),
        .i_fill_addr   (addr_i_q),
        .i_fill_data   (i_mem_data),
        .i_inval       (buf_inval),
        .i_inval_addr  (addr_d_q),
        .i_lookup_addr (buf_lookup_addr),
        .o_hit         (buf_hit),
        .o_data        (buf_data)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_d    = state_q;
        o_mem_req  = 1'b0;
        o_mem_addr = '0;
        o_mem_rd   = 1'b0;
        o_mem_we   = '0;
        o_mem_data = '0;
        cap_i      = 1'b0;
        cap_d      = 1'b0;
        take_buf   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_data_access(i_rd_d, i_we_d)) begin
                    state_d = S_DATA;
                end else if (buf_hit) begin
                    state_d  = S_DONE;
                    take_buf = 1'b1;
                end else begin
                    state_d = S_INSTR;
                end
            end
            S_DATA: begin
                o_mem_req  = 1'b1;
                o_mem_addr = addr_d_q;
                o_mem_rd   = rd_q;
                o_mem_we   = we_q;
                o_mem_data = wdata_q;
                if (i_mem_ack) begin
                    cap_d = rd_q;
                    if (buf_hit) begin
                        state_d  = S_DONE;
                        take_buf = 1'b1;
                    end else begin
                        state_d = S_INSTR;
                    end
                end
            end
            S_INSTR: begin
                o_mem_req  = 1'b1;
                o_mem_addr = addr_i_q;
                o_mem_rd   = 1'b1;
                if (i_mem_ack) begin
                    cap_i   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            addr_i_q <= '0;
            addr_d_q <= '0;
            rd_q     <= 1'b0;
            we_q     <= '0;
            wdata_q  <= '0;
            data_i_q <= '0;
            data_d_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                addr_i_q <= i_addr_i;
                addr_d_q <= i_addr_d;
                rd_q     <= i_rd_d;
                we_q     <= i_we_d;
                wdata_q  <= i_data_d;
            end
            if (cap_i) begin
                data_i_q <= i_mem_data;
            end else if (take_buf) begin
                data_i_q <= buf_data;
            end
            if (cap_d) begin
                data_d_q <= i_mem_data;
            end
        end
    end

    assign o_data_i  = data_i_q;
    assign o_data_d  = data_d_q;
    assign o_valid_i = (state_q == S_DONE);
    assign o_valid_d = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a wait-state memory responder.
// Fetch-buffer expectations follow ARB_IFETCH_BUF_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef ARB_IFETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_addr_i = '0;
    logic [31:0] o_data_i;
    logic        o_valid_i;
    logic [31:0] i_addr_d = '0;
    logic        i_rd_d = 1'b0;
    logic [3:0]  i_we_d = '0;
    logic [31:0] i_data_d = '0;
    logic [31:0] o_data_d;
    logic        o_valid_d;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_rd;
    logic [3:0]  o_mem_we;
    logic [31:0] o_mem_data;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int waits = 0;
    int wcnt = 0;
    bit force_ack = 1'b0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(
        .AW (32),
        .DW (32)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_addr_i   (i_addr_i),
        .o_data_i   (o_data_i),
        .o_valid_i  (o_valid_i),
        .i_addr_d   (i_addr_d),
        .i_rd_d     (i_rd_d),
        .i_we_d     (i_we_d),
        .i_data_d   (i_data_d),
        .o_data_d   (o_data_d),
        .o_valid_d  (o_valid_d),
        .o_mem_req  (o_mem_req),
        .o_mem_addr (o_mem_addr),
        .o_mem_rd   (o_mem_rd),
        .o_mem_we   (o_mem_we),
        .o_mem_data (o_mem_data),
        .i_mem_ack  (i_mem_ack),
        .i_mem_data (i_mem_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_2000: return 32'hCAFE_F00D;
            default:       return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: acks after `waits` stall cycles; force_ack drives a spurious ack.
    always @(negedge i_clk) begin
        if (force_ack) begin
            i_mem_ack  = 1'b1;
            i_mem_data = 32'hBAD0_BAD0;
            wcnt       = 0;
        end else if (o_mem_req) begin
            if (wcnt == waits) begin
                i_mem_ack  = 1'b1;
                i_mem_data = mem_word(o_mem_addr);
                wcnt       = 0;
            end else begin
                i_mem_ack  = 1'b0;
                i_mem_data = 32'hFFFF_FFFF;
                wcnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge i_clk);
            seen = (dut.state_q == S_IDLE);
        end
        check_eq("wait_idle", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        check_eq("rst_state", dut.state_q, S_IDLE);
        check_eq("rst_req", o_mem_req, 1'b0);
        check_eq("rst_addr", o_mem_addr, 32'h0);
        check_eq("rst_valid", {o_valid_i, o_valid_d}, 2'b00);
        check_eq("rst_data", {o_data_i, o_data_d}, 64'h0);
        i_rst = 1'b0;

        // Fetch only, zero-wait memory
        wait_idle();
        waits    = 0;
        i_addr_i = 32'h100;
        @(negedge i_clk);
        check_eq("f_req", {o_mem_req, o_mem_rd, o_mem_we}, {2'b11, 4'b0000});
        check_eq("f_addr", o_mem_addr, 32'h100);
        check_eq("f_valid0", o_valid_i, 1'b0);
        @(negedge i_clk);
        check_eq("f_valid", {o_valid_i, o_valid_d}, 2'b11);
        check_eq("f_data", o_data_i, 32'h13);
        check_eq("f_idle_req", {o_mem_req, o_mem_addr}, 33'h0);

        // Load plus fetch, two wait states each
        wait_idle();
        waits    = 2;
        i_addr_i = 32'h104;
        i_addr_d = 32'h2000;
        i_rd_d   = 1'b1;
        @(negedge i_clk);
        i_rd_d = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("ld_state", dut.state_q, S_DATA);
            check_eq("ld_req", {o_mem_req, o_mem_rd, o_mem_we}, {2'b11, 4'b0000});
            check_eq("ld_addr", o_mem_addr, 32'h2000);
            check_eq("ld_valid0", o_valid_d, 1'b0);
            @(negedge i_clk);
        end
        for (int c = 0; c < 3; c++) begin
            check_eq("ldf_addr", {o_mem_req, o_mem_rd, o_mem_addr}, {2'b11, 32'h104});
            @(negedge i_clk);
        end
        check_eq("ld_valid", {o_valid_i, o_valid_d}, 2'b11);
        check_eq("ld_data_d", o_data_d, 32'hCAFE_F00D);
        check_eq("ld_data_i", o_data_i, 32'h5A5A_0104);
        @(negedge i_clk);
        check_eq("ld_pulse", {o_valid_i, o_valid_d}, 2'b00);

        // Store: write data on the bus, o_data_d left alone
        wait_idle();
        waits    = 1;
        i_addr_i = 32'h108;
        i_addr_d = 32'h2004;
        i_we_d   = 4'b0011;
        i_data_d = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_we_d = 4'b0000;
        check_eq("st_we", {o_mem_req, o_mem_rd, o_mem_we}, {2'b10, 4'b0011});
        check_eq("st_wdata", o_mem_data, 32'hDEAD_BEEF);
        check_eq("st_addr", o_mem_addr, 32'h2004);
        repeat (4) @(negedge i_clk);
        check_eq("st_valid", {o_valid_i, o_valid_d}, 2'b11);
        check_eq("st_data_d", o_data_d, 32'hCAFE_F00D);
        check_eq("st_data_i", o_data_i, 32'h5A5A_0108);

        // Reset during S_DATA with a late ack, then spurious ack in S_IDLE/S_DONE
        wait_idle();
        waits    = 1;
        i_addr_d = 32'h3000;
        i_rd_d   = 1'b1;
        @(negedge i_clk);
        check_eq("rs_in_data", dut.state_q, S_DATA);
        i_rst     = 1'b1;
        force_ack = 1'b1;
        i_rd_d    = 1'b0;
        i_addr_d  = 32'h0;
        i_addr_i  = 32'h10C;
        @(negedge i_clk);
        check_eq("rs_state", dut.state_q, S_IDLE);
        check_eq("rs_bus", {o_mem_req, o_mem_rd, o_mem_we, o_mem_addr}, 38'h0);
        check_eq("rs_valid", {o_valid_i, o_valid_d}, 2'b00);
        check_eq("rs_data", {o_data_i, o_data_d}, 64'h0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_eq("sp_idle_adv", dut.state_q, S_INSTR);
        check_eq("sp_idle_cap", {o_data_i, o_data_d}, 64'h0);
        @(negedge i_clk);
        check_eq("sp_done", dut.state_q, S_DONE);
        check_eq("sp_data_i", o_data_i, 32'hBAD0_BAD0);
        @(negedge i_clk);
        check_eq("sp_done_adv", dut.state_q, S_IDLE);
        check_eq("sp_done_cap", {o_data_i, o_data_d}, {32'hBAD0_BAD0, 32'h0});
        force_ack = 1'b0;

        // Repeated fetch of 0x100, then store to 0x100 and fetch again
        wait_idle();
        waits    = 0;
        i_addr_i = 32'h100;
        @(negedge i_clk);
        check_eq("bf_first", dut.state_q, S_INSTR);
        @(negedge i_clk);
        check_eq("bf_first_data", o_data_i, 32'h13);
        @(negedge i_clk);
        check_eq("bf_idle", dut.state_q, S_IDLE);
        @(negedge i_clk);
        check_eq("bf_second", dut.state_q, BUF_EN ? S_DONE : S_INSTR);
        check_eq("bf_second_req", o_mem_req, !BUF_EN);
        check_eq("bf_second_valid", o_valid_i, BUF_EN);
        wait_idle();
        i_addr_d = 32'h100;
        i_we_d   = 4'b1111;
        i_data_d = 32'h1111_1111;
        @(negedge i_clk);
        i_we_d = 4'b0000;
        check_eq("bw_store", {o_mem_req, o_mem_we, o_mem_data}, {1'b1, 4'b1111, 32'h1111_1111});
        @(negedge i_clk);
        check_eq("bw_refetch", dut.state_q, S_INSTR);
        check_eq("bw_refetch_bus", {o_mem_req, o_mem_rd, o_mem_addr}, {2'b11, 32'h100});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected $finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, sets the address width of all address ports.
REQ-002 Parameter DW, default 32, sets the data width of all data ports.
REQ-003 i_clk  in  1  the single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset; synchronous, active-high.
REQ-005 i_addr_i  in  AW  instruction fetch address from the core.
REQ-006 o_data_i  out  DW  fetched instruction word.
REQ-007 o_valid_i  out  1  instruction word valid; the core advances only when both valids are high.
REQ-008 i_addr_d  in  AW  data access address.
REQ-009 i_rd_d  in  1  data read request; must not be gated by o_valid_*.
REQ-010 i_we_d  in  4  data byte write enables; must not be gated by o_valid_*.
REQ-011 i_data_d  in  DW  data write word.
REQ-012 o_data_d  out  DW  data read word.
REQ-013 o_valid_d  out  1  data access complete.
REQ-014 o_mem_req  out  1  shared memory request.
REQ-015 o_mem_addr  out  AW  shared memory address.
REQ-016 o_mem_rd  out  1  shared memory read strobe.
REQ-017 o_mem_we  out  4  shared memory byte write enables.
REQ-018 o_mem_data  out  DW  shared memory write data.
REQ-019 i_mem_ack  in  1  memory completes the current request this cycle.
REQ-020 i_mem_data  in  DW  memory read data, valid with i_mem_ack.

Function
REQ-021 The block SHALL use a four-state FSM: S_IDLE, S_DATA, S_INSTR, S_DONE.
REQ-022 In S_IDLE the block SHALL latch i_addr_i, i_addr_d, i_rd_d, i_we_d and i_data_d, then go to S_DATA if i_rd_d or |i_we_d, else to S_INSTR.
REQ-023 Data access SHALL have priority over instruction fetch within a transaction.
REQ-024 In S_DATA the block SHALL drive o_mem_req=1 with the latched data address, rd, we and write data.
- On i_mem_ack it SHALL capture i_mem_data into o_data_d (read) and go to S_INSTR.
REQ-025 In S_INSTR the block SHALL drive o_mem_req=1, o_mem_rd=1 and o_mem_we=0 with the latched instruction address.
- On i_mem_ack it SHALL capture i_mem_data into o_data_i and go to S_DONE.
REQ-026 Request signals SHALL be held stable while o_mem_req=1 and i_mem_ack=0, for any number of wait cycles.
REQ-027 An ack in the first request cycle (zero-wait memory) SHALL be accepted; minimum latency is S_IDLE to o_valid high in 3 cycles with no data access, and 4 cycles with one.
REQ-028 In S_DONE, o_valid_i and o_valid_d SHALL both be 1 for exactly one cycle, then the FSM SHALL return to S_IDLE.
REQ-029 In all other states both valids SHALL be 0.
REQ-030 When o_mem_req=0, o_mem_addr, o_mem_rd, o_mem_we and o_mem_data SHALL all be 0.
REQ-031 i_mem_ack SHALL be ignored while o_mem_req=0.
REQ-032 o_data_d SHALL retain its previous value on write-only transactions; o_data_i and o_data_d SHALL hold their values until the next capture.

Reset
REQ-033 On i_rst the FSM SHALL go to S_IDLE, and o_valid_*, o_data_*, all latches and the fetch buffer (if present) SHALL clear to 0.
REQ-034 A reset mid-transaction SHALL abandon the transaction; o_mem_req SHALL be 0 in the first cycle after the reset edge, and any late ack SHALL be ignored.

Configuration
REQ-035 With ARB_IFETCH_BUF_EN defined, the block SHALL keep a one-entry buffer (address, word, valid bit).
- In S_IDLE or after S_DATA, if the latched i_addr_i equals the buffered address and the buffer is valid, the block SHALL skip S_INSTR, go to S_DONE, and drive o_data_i from the buffer.
- Every completed fetch SHALL refill the buffer.
- A data write whose word address equals the buffered address SHALL invalidate the buffer.
REQ-036 Without ARB_IFETCH_BUF_EN, every transaction SHALL execute S_INSTR and no buffer storage SHALL exist.

Structure
REQ-037 The state encodings (S_IDLE=0, S_DATA=1, S_INSTR=2, S_DONE=3) SHALL live in a shared mem_arbiter_pkg header included by the block and the bench.
REQ-038 The fetch buffer SHALL be a sub-module, ifetch_buf, instantiated only under ARB_IFETCH_BUF_EN.

Verification
REQ-039 Fetch only, ack in the same cycle: addr_i=0x100, mem_data=0x00000013 -> o_mem_addr=0x100 one cycle, valids high in the 3rd cycle, o_data_i=0x13.
REQ-040 Load plus fetch, 2 wait states each: addr_d=0x2000, rd=1 -> data request first, held stable 3 cycles, then fetch; o_data_d equals the memory word; valids pulse once.
REQ-041 Store: we=4'b0011, data=0xDEADBEEF, addr_d=0x2004 -> o_mem_we=0011, o_mem_data=0xDEADBEEF, o_mem_rd=0; o_data_d unchanged.
REQ-042 Reset in S_DATA with ack arriving the next cycle -> o_mem_req=0 after the edge, ack ignored, FSM in S_IDLE, all outputs 0.
REQ-043 With ARB_IFETCH_BUF_EN: fetch 0x100 twice -> the second fetch issues no memory request (valids high in the 2nd cycle); a store to 0x100 followed by a fetch of 0x100 -> a memory fetch is issued.
REQ-044 Spurious i_mem_ack held high in S_IDLE and S_DONE -> no state change, no data capture.
